// File: rtl/arb_types_pkg.sv
// Shared types and default widths for the I/D cache line arbiter.
package arb_types_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_op_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/arb_req_latch.sv
// Capture registers for the granted request: address, operation and write line.
module arb_req_latch
    import arb_types_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  arb_op_t           op,
    input  logic [LINE_W-1:0] wdata,
    output logic [ADDR_W-1:0] lat_address,
    output arb_op_t           lat_op,
    output logic [LINE_W-1:0] lat_wdata
);

    // Load the selected request on grant; hold it for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_address <= {ADDR_W{1'b0}};
            lat_op      <= ARB_RD;
            lat_wdata   <= {LINE_W{1'b0}};
        end else if (load) begin
            lat_address <= address;
            lat_op      <= op;
            lat_wdata   <= wdata;
        end else begin
            lat_address <= lat_address;
            lat_op      <= lat_op;
            lat_wdata   <= lat_wdata;
        end
    end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares one memory line port between I-side and D-side miss paths.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both sides request together.
module cache_line_arbiter
    import arb_types_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic              d_req_s;
    logic              any_req_s;
    logic              grant_d_s;
    logic              load_s;
    logic              serving_next_s;
    arb_op_t           sel_op_s;
    arb_op_t           next_op_s;
    logic [ADDR_W-1:0] sel_address_s;
    logic [ADDR_W-1:0] lat_address_s;
    arb_op_t           lat_op_s;
    logic [LINE_W-1:0] lat_wdata_s;
    logic [LINE_W-1:0] line_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              i_resp_r;
    logic              d_resp_r;

`ifdef ARB_ROUND_ROBIN_EN
    arb_side_t         last_grant_r;
`endif

    // Grant selection: D over I, or alternating when both contend.
    always_comb begin
        d_req_s   = d_read | d_write;
        any_req_s = d_req_s | i_read;
        grant_d_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req_s && i_read) begin
            grant_d_s = (last_grant_r == GNT_I);
        end else begin
            grant_d_s = d_req_s;
        end
`else
        grant_d_s = d_req_s;
`endif
        sel_address_s = grant_d_s ? d_address : i_address;
        // A simultaneous read+write on the D side is a writeback.
        sel_op_s      = (grant_d_s && d_write) ? ARB_WR : ARB_RD;
    end

    // Next-state logic and the op that the next cycle will present to memory.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    load_s       = 1'b1;
                    state_next_s = grant_d_s ? SERVE_D : SERVE_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    state_next_s = RESP_I;
                end else begin
                    state_next_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    state_next_s = RESP_D;
                end else begin
                    state_next_s = SERVE_D;
                end
            end
            RESP_I:  state_next_s = IDLE;
            RESP_D:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        next_op_s      = load_s ? sel_op_s : lat_op_s;
        serving_next_s = (state_next_s == SERVE_I) || (state_next_s == SERVE_D);
    end

    // State register and registered strobes / response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_resp_r    <= 1'b0;
            d_resp_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mem_read_r  <= serving_next_s && (next_op_s == ARB_RD);
            mem_write_r <= serving_next_s && (next_op_s == ARB_WR);
            i_resp_r    <= (state_next_s == RESP_I);
            d_resp_r    <= (state_next_s == RESP_D);
        end
    end

    // Returned line, captured only while a transaction is in service.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= {LINE_W{1'b0}};
        end else if (((state_r == SERVE_I) || (state_r == SERVE_D)) && mem_resp) begin
            line_r <= mem_rdata;
        end else begin
            line_r <= line_r;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which side was granted most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= GNT_I;
        end else if (load_s) begin
            last_grant_r <= grant_d_s ? GNT_D : GNT_I;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    arb_req_latch #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_latch (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .address     (sel_address_s),
        .op          (sel_op_s),
        .wdata       (d_wdata),
        .lat_address (lat_address_s),
        .lat_op      (lat_op_s),
        .lat_wdata   (lat_wdata_s)
    );

    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_address = lat_address_s;
    assign mem_wdata   = lat_wdata_s;
    assign i_resp      = i_resp_r;
    assign d_resp      = d_resp_r;
    assign i_rdata     = line_r;
    assign d_rdata     = line_r;

endmodule
